enc_stage_select_fifo: RTL

Parametrised successor to the encryption process output selector. It picks one of `NUM_SRC` round-stage results (AddRoundKey, SubBytes, MixColumns, ShiftRows, and any added stages) and captures the selection into a `DEPTH`-entry FIFO. The FIFO has valid/ready handshakes on both sides. It sits between the AES round datapath and the output/key-schedule consumer, and decouples consumer stalls from the round controller.

---
 rtl/enc_stage_select_fifo.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/enc_stage_select_fifo.sv
// Purpose : pick one of NUM_SRC AES round-stage results and buffer it in a DEPTH-entry FIFO.
// Latency : 1 cycle from push to out_valid; no same-cycle bypass.
// Backpr. : in_ready drops when full, during flush or during rst; it never looks at out_ready.
//
// Ports:
//   clk, rst             sole clock, synchronous active-high reset
//   flush                discard all buffered entries (stored data left untouched)
//   process_output       source select, sampled on push
//   src_data             flattened sources, source i at [i*DATA_W +: DATA_W]
//   in_valid / in_ready  producer handshake
//   process_out_data     head-of-FIFO word, zero while out_valid is 0
//   out_valid / out_ready consumer handshake
//   count                occupied entries
//   sel_err              sticky illegal-select flag
//
// Build option: define ENC_STAGE_SELECT_ERR_EN to store zero and raise sel_err on an
// out-of-range select. Without it an out-of-range select stores source 0 and sel_err is 0.
module enc_stage_select_fifo #(
    parameter int DATA_W  = 128,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [SEL_W-1:0]            process_output,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           process_out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        sel_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sel_word;
    logic              push, pop;

    // ------------------------------------------------------------------
    // Source select
    // ------------------------------------------------------------------
`ifdef ENC_STAGE_SELECT_ERR_EN
    logic sel_illegal;
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_word    = '0;
        sel_illegal = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (process_output == SEL_W'(i)) begin
                sel_word    = src_data[i*DATA_W +: DATA_W];
                sel_illegal = 1'b0;
            end
        end
    end

    always_comb begin
        sel_err_d = sel_err_q;
        if (push && sel_illegal) begin
            sel_err_d = 1'b1;
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_word = src_data[0 +: DATA_W];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (process_output == SEL_W'(i)) begin
                sel_word = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // rst is included so the producer sees in_ready low in the reset cycle
    // even though count_q may still hold a stale value.
    assign in_ready  = !rst && !flush && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    // A pop offered during flush is not a transfer.
    assign pop       = out_valid && out_ready && !flush;

    // ------------------------------------------------------------------
    // Pointer / count next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of 2, so pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_word;
        end
    end

    assign process_out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count            = count_q;

endmodule
